// File: rtl/scan_code_filter.sv
// PS/2 scan-code filter: strips E0/F0 prefixes, suppresses typematic repeat and
// host-protocol bytes, and emits each new make code as a one-cycle registered pulse.
module scan_code_filter #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] scan_code_out,
    output logic       code_valid,
    output logic       key_held
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Expiry is taken on the last idle cycle so the FSM is back in IDLE exactly
    // TIMEOUT_CYCLES cycles after the prefix state was entered.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BREAK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    held_code;

    logic       is_ignored;
    logic       is_error;
    logic       is_prefix;
    logic       timeout_hit;
    logic       emit;
    logic [7:0] emit_code;
    logic       set_held;
    logic       clr_held;

    assign is_ignored  = (byte_in == 8'hAA) || (byte_in == 8'hFA) ||
                         (byte_in == 8'hEE) || (byte_in == 8'hFE);
    assign is_error    = (byte_in == 8'h00) || (byte_in == 8'hFF);
    assign is_prefix   = (byte_in == 8'hE0) || (byte_in == 8'hF0);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state != IDLE) && !byte_valid && (tmo_cnt == TMO_LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || byte_valid || state == IDLE || timeout_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (byte_valid) begin
            case (state)
                IDLE, EXT: begin
                    if (is_ignored) begin
                        state_next = state;
                    end else if (is_error) begin
                        state_next = IDLE;
                    end else if (byte_in == 8'hF0) begin
                        state_next = BREAK;
                    end else if (byte_in == 8'hE0) begin
                        state_next = EXT;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_code = byte_in;
        set_held  = 1'b0;
        clr_held  = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE, EXT: begin
                    if (is_error) begin
                        emit      = 1'b1;
                        emit_code = 8'hFF;
                    end else if (!is_ignored && !is_prefix) begin
                        if (!(key_held && byte_in == held_code)) begin
                            emit     = 1'b1;
                            set_held = 1'b1;
                        end
                    end
                end
                default: begin
                    if (!is_prefix && !is_error && key_held && byte_in == held_code) begin
                        clr_held = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: held_code is reset along with key_held so a reset mid-sequence can
    // never let a stale code masquerade as a typematic repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_code_out <= 8'h00;
            code_valid    <= 1'b0;
            key_held      <= 1'b0;
            held_code     <= 8'h00;
        end else begin
            code_valid <= emit;
            if (emit) begin
                scan_code_out <= emit_code;
            end
            if (set_held) begin
                held_code <= byte_in;
                key_held  <= 1'b1;
            end else if (clr_held) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_code_filter.sv
// Directed, table-driven bench for scan_code_filter with TIMEOUT_CYCLES=8 and
// hand-written timeout and mid-sequence reset sequences.
module tb_scan_code_filter;

    localparam int TMO = 8;

    logic       clk;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] scan_code_out;
    logic       code_valid;
    logic       key_held;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       rst;
        logic       bv;
        logic [7:0] b;
        logic       ev;
        logic [7:0] ec;
        logic       eh;
        string      name;
    } vec_t;

    vec_t vecs[$];

    scan_code_filter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .scan_code_out(scan_code_out),
        .code_valid   (code_valid),
        .key_held     (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic bv, input logic [7:0] b,
                                input logic ev, input logic [7:0] ec, input logic eh,
                                input string name);
        vec_t v;
        v.rst = r; v.bv = bv; v.b = b; v.ev = ev; v.ec = ec; v.eh = eh; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic ev, input logic [7:0] ec,
                         input logic eh);
        n_vec++;
        if (code_valid !== ev || scan_code_out !== ec || key_held !== eh) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b code=%02h held=%0b, want valid=%0b code=%02h held=%0b",
                     name, code_valid, scan_code_out, key_held, ev, ec, eh);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, check just after the rising edge.
    task automatic step(input logic r, input logic bv, input logic [7:0] b,
                        input logic ev, input logic [7:0] ec, input logic eh,
                        input string name);
        @(negedge clk);
        rst        = r;
        byte_valid = bv;
        byte_in    = b;
        @(posedge clk);
        #1;
        check(name, ev, ec, eh);
    endtask

    task automatic idle(input int n, input logic [7:0] ec, input logic eh, input string name);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, ec, eh, name);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;

        vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, "reset0"));
        vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, "reset1"));
        // press, typematic repeat, release, press again
        vecs.push_back(mk(0, 1, 8'h16, 1, 8'h16, 1, "make16"));
        vecs.push_back(mk(0, 1, 8'h16, 0, 8'h16, 1, "repeat16a"));
        vecs.push_back(mk(0, 1, 8'h16, 0, 8'h16, 1, "repeat16b"));
        vecs.push_back(mk(0, 1, 8'hF0, 0, 8'h16, 1, "break_pfx"));
        vecs.push_back(mk(0, 1, 8'h16, 0, 8'h16, 0, "break16"));
        vecs.push_back(mk(0, 1, 8'h16, 1, 8'h16, 1, "remake16"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h16, 1, "pulse_one_cycle"));
        // extended make and extended break
        vecs.push_back(mk(0, 1, 8'hE0, 0, 8'h16, 1, "ext_pfx"));
        vecs.push_back(mk(0, 1, 8'h5A, 1, 8'h5A, 1, "ext_make5A"));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 8'h5A, 1, "extbrk_e0"));
        vecs.push_back(mk(0, 1, 8'hF0, 0, 8'h5A, 1, "extbrk_f0"));
        vecs.push_back(mk(0, 1, 8'h5A, 0, 8'h5A, 0, "extbrk_5A"));
        // foreign break, error byte, ignored bytes
        vecs.push_back(mk(0, 1, 8'h1E, 1, 8'h1E, 1, "make1E"));
        vecs.push_back(mk(0, 1, 8'hF0, 0, 8'h1E, 1, "fbrk_f0"));
        vecs.push_back(mk(0, 1, 8'h26, 0, 8'h1E, 1, "fbrk_26"));
        vecs.push_back(mk(0, 1, 8'h00, 1, 8'hFF, 1, "err00"));
        vecs.push_back(mk(0, 1, 8'hAA, 0, 8'hFF, 1, "ign_AA"));
        vecs.push_back(mk(0, 1, 8'hFA, 0, 8'hFF, 1, "ign_FA"));
        vecs.push_back(mk(0, 1, 8'h1E, 0, 8'hFF, 1, "held_still_1E"));
        // error and ignored bytes inside EXT
        vecs.push_back(mk(0, 1, 8'hE0, 0, 8'hFF, 1, "ext_pfx2"));
        vecs.push_back(mk(0, 1, 8'hFF, 1, 8'hFF, 1, "ext_errFF"));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 8'hFF, 1, "ext_pfx3"));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 8'hFF, 1, "ext_ignEE"));
        vecs.push_back(mk(0, 1, 8'h6B, 1, 8'h6B, 1, "ext_make6B"));
        // error byte in BREAK abandons the sequence silently
        vecs.push_back(mk(0, 1, 8'hF0, 0, 8'h6B, 1, "brk_f0"));
        vecs.push_back(mk(0, 1, 8'hFF, 0, 8'h6B, 1, "brk_errFF"));
        vecs.push_back(mk(0, 1, 8'h6B, 0, 8'h6B, 1, "repeat6B"));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].bv, vecs[i].b, vecs[i].ev, vecs[i].ec, vecs[i].eh,
                 vecs[i].name);
        end

        // break abandoned by timeout: 45 is a fresh make
        step(0, 1, 8'hF0, 0, 8'h6B, 1, "to_f0");
        idle(10, 8'h6B, 1, "to_wait10");
        step(0, 1, 8'h45, 1, 8'h45, 1, "to_make45");

        // byte on the expiry cycle wins: treated as the break of 45
        step(0, 1, 8'hF0, 0, 8'h45, 1, "exp_f0");
        idle(TMO - 1, 8'h45, 1, "exp_wait");
        step(0, 1, 8'h45, 0, 8'h45, 0, "exp_break45");

        // one cycle later the break has already been abandoned
        step(0, 1, 8'hF0, 0, 8'h45, 0, "late_f0");
        idle(TMO, 8'h45, 0, "late_wait");
        step(0, 1, 8'h33, 1, 8'h33, 1, "late_make33");

        // reset mid-sequence drops both the E0 prefix and the held key
        step(0, 1, 8'h3D, 1, 8'h3D, 1, "mid_make3D");
        step(0, 1, 8'hE0, 0, 8'h3D, 1, "mid_e0");
        step(1, 0, 8'h00, 0, 8'h00, 0, "mid_rst");
        step(0, 1, 8'h3D, 1, 8'h3D, 1, "post_rst_3D");
        step(0, 0, 8'h00, 0, 8'h3D, 1, "post_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_code_filter.md
# scan_code_filter

Byte-level PS/2 scan-code filter between the PS/2 byte receiver and `convert_to_binary`. It strips E0 extended prefixes and F0 break sequences. It suppresses typematic auto-repeat of a held key and discards host-protocol bytes. Each new make code is emitted as a one-cycle `code_valid` pulse with a registered `scan_code_out`, which the downstream LUT consumes directly.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 50000: idle clock cycles after a prefix byte before the partial sequence is abandoned. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `byte_in`  in  8  received PS/2 byte; sampled only when `byte_valid`=1.
- `byte_valid`  in  1  one-cycle strobe, one per received byte.
- `scan_code_out`  out  8  last emitted code; holds its value between pulses.
- `code_valid`  out  1  one-cycle pulse when `scan_code_out` carries a new code.
- `key_held`  out  1  1 while a make code is latched and its break has not yet arrived.

## Operation

- State machine states: IDLE, EXT (E0 seen), BREAK (F0 seen).
- Internal registers:
  - `held_code[7:0]` plus `key_held`.
  - Timeout counter, width $clog2(TIMEOUT_CYCLES+1).
- Ignored bytes: 0xAA, 0xFA, 0xEE, 0xFE. In IDLE or EXT these cause no output, no state change and no held change.
- Error bytes: 0x00 and 0xFF. In IDLE or EXT they emit 0xFF (downstream ERROR), go to IDLE, and leave held unchanged.
- IDLE:
  - 0xF0 → BREAK.
  - 0xE0 → EXT.
  - Any other byte c is a make code.
- EXT:
  - 0xF0 → BREAK.
  - 0xE0 → stay in EXT.
  - Any other byte c is a make code with the prefix stripped (E0 5A emits 5A); → IDLE.
- Make-code processing for byte c:
  - If `key_held`=1 and c==`held_code`: typematic repeat; no output.
  - Otherwise emit c, set `held_code`=c and `key_held`=1.
- BREAK: any byte c → IDLE, with no output.
  - If `key_held`=1 and c==`held_code`, clear `key_held`.
  - A break of any other key changes nothing.
  - 0xE0, 0xF0 or an error byte in BREAK: sequence is abandoned; → IDLE, no output, held unchanged.
- Timeout:
  - The counter clears on every `byte_valid`.
  - It increments each cycle while in EXT or BREAK, and is held at 0 in IDLE.
  - When the counter reaches TIMEOUT_CYCLES without a byte → IDLE. No output; held unchanged.
- Simultaneous events: if `byte_valid` coincides with the timeout expiry cycle, the byte wins and is processed in the current state.
- Reset:
  - Outputs: `scan_code_out`=0x00 (downstream EMPTY), `code_valid`=0, `key_held`=0.
  - Internal: state IDLE, `held_code`=0x00, counter 0.
  - Reset mid-sequence discards any partial prefix and held key.

## Timing

- Fully registered outputs.
- Latency: byte_valid at cycle n → code_valid=1 and new scan_code_out at cycle n+1.
- `code_valid` is high for exactly one cycle. It is never high in two consecutive cycles unless `byte_valid` was high in two consecutive cycles.
- `key_held` updates in the same cycle n+1 as the corresponding emit or clear.
- Back-to-back `byte_valid` on every cycle is supported with no loss.
- Timeout: with a prefix byte at cycle n and no further bytes, state is IDLE from cycle n+1+TIMEOUT_CYCLES.

## Test plan

- **Reset values:** assert rst 2 cycles → scan_code_out=0x00, code_valid=0, key_held=0.
- **Press, repeat, release:** bytes 16,16,16,F0,16,16 → single pulse with 0x16 after the first byte; key_held cleared one cycle after the break's 16; a second pulse with 0x16 after the final byte.
- **Extended keys:** E0 5A → one pulse 0x5A. Then E0 F0 5A → key_held=0 and no pulse.
- **Foreign break and error bytes:** 1E, then F0 26 → no pulse, key_held stays 1 and held stays 0x1E. Then 00 → pulse with 0xFF. Then AA FA → no pulse.
- **Timeout (TIMEOUT_CYCLES=8):**
  - F0, wait 10 cycles, 45 → pulse 0x45, because the break was abandoned.
  - F0, then 45 arriving exactly on the expiry cycle → treated as a break; no pulse.
- **Reset mid-sequence:** 3D then E0, assert rst, then 3D → pulse 0x3D, because the held key was cleared by reset.
